// File: rtl/ifu_prefetch_buf.sv
// ifu_prefetch_buf
//   Instruction prefetch buffer. Keeps up to MAX_OUTSTANDING word reads in
//   flight on the RIB master port. Returned words go into a FIFO_DEPTH-entry
//   queue. 16-bit and 32-bit instructions are extracted at any halfword-aligned
//   PC, including 32-bit instructions that straddle two words. A redirect
//   (flush) empties the queue. Responses to reads issued before the redirect
//   are counted off and discarded.
//
// Ports
//   i_clk, i_rstn         clock, synchronous active-low reset
//   i_flush, i_flush_pc   redirect request and target PC
//   o_inst*               instruction, PC, 16-bit flag, valid
//   i_inst_rdy            decode accepts o_inst
//   o_misalign_err        redirect target was odd; fetch halted until an
//                         even redirect
//   o_ribm_*, i_ribm_*    RIB master, read-only word fetches
module ifu_prefetch_buf #(
  parameter int unsigned    XLEN            = 32,
  parameter int unsigned    FIFO_DEPTH      = 4,
  parameter int unsigned    MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_is16,
  output logic            o_inst_vld,
  input  logic            i_inst_rdy,
  output logic            o_misalign_err,
  output logic [31:0]     o_ribm_addr,
  output logic            o_ribm_wrcs,
  output logic [3:0]      o_ribm_mask,
  output logic [31:0]     o_ribm_wdata,
  input  logic [31:0]     i_ribm_rdata,
  output logic            o_ribm_req,
  input  logic            i_ribm_gnt,
  input  logic            i_ribm_rsp,
  output logic            o_ribm_rdy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_fa;
  logic [XLEN-1:0] r_pc;
  logic [OW-1:0]   r_outst;
  logic [OW-1:0]   r_drop;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_rdptr;
  logic [PW-1:0]   r_wrptr;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic [CW:0]     w_inflight;
  logic            w_req;
  logic            w_issue;
  logic            w_rsp;
  logic            w_push;
  logic [OW-1:0]   w_outst_nxt;
  logic [31:0]     w_w0;
  logic [31:0]     w_w1;
  logic [15:0]     w_half;
  logic            w_is16;
  logic            w_avail;
  logic            w_vld;
  logic            w_consume;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [XLEN-1:0] w_pc_step;

  // Every issued read has a reserved FIFO slot, so a response never finds
  // the queue full.
  assign w_inflight = (CW+1)'(r_count) + (CW+1)'(r_outst);
  assign w_req      = i_rstn & ~i_flush & ~r_err
                    & (r_outst < MAX_OUT_C) & (w_inflight < DEPTH_C);
  assign w_issue    = w_req & i_ribm_gnt;
  // A response with nothing outstanding cannot be legal, so it is ignored.
  assign w_rsp      = i_ribm_rsp & (r_outst != '0);
  assign w_push     = w_rsp & ~i_flush & (r_drop == '0);

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_issue & ~w_rsp)
      w_outst_nxt = r_outst + OW'(1);
    else if (~w_issue & w_rsp)
      w_outst_nxt = r_outst - OW'(1);
  end

  // Instruction extraction from the queue head and the entry behind it
  assign w_w0   = r_mem[r_rdptr];
  assign w_w1   = r_mem[r_rdptr + PW'(1)];
  assign w_half = r_pc[1] ? w_w0[31:16] : w_w0[15:0];
  assign w_is16 = (w_half[1:0] != 2'b11);

  always_comb begin
    w_avail = 1'b0;
    if (w_is16 | ~r_pc[1])
      w_avail = (r_count != '0);
    else
      w_avail = (r_count >= CW'(2));
  end

  assign w_vld = i_rstn & ~i_flush & w_avail;

  always_comb begin
    o_inst = w_w0;
    if (w_is16)
      o_inst = {16'h0000, w_half};
    else if (r_pc[1])
      o_inst = {w_w1[15:0], w_w0[31:16]};
  end

  assign w_consume = w_vld & i_inst_rdy;
  // A straddling 32-bit instruction retires only the lower word. The upper
  // half of the next word becomes the head, and pc[1] stays set.
  assign w_pop     = w_consume & (r_pc[1] | ~w_is16);
  assign w_pc_step = w_is16 ? XLEN'(2) : XLEN'(4);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push & ~w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (~w_push & w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_fa    <= {RESET_PC[XLEN-1:2], 2'b00};
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_flush) begin
      r_fa    <= {i_flush_pc[XLEN-1:2], 2'b00};
      r_pc    <= i_flush_pc;
      r_outst <= w_outst_nxt;
      // Everything still in flight after this edge belongs to the old stream.
      r_drop  <= w_outst_nxt;
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_count <= '0;
      r_err   <= i_flush_pc[0];
    end else begin
      if (w_issue)
        r_fa <= r_fa + XLEN'(4);
      r_outst <= w_outst_nxt;
      if (w_rsp && (r_drop != '0))
        r_drop <= r_drop - OW'(1);
      if (w_push)
        r_wrptr <= r_wrptr + PW'(1);
      if (w_pop)
        r_rdptr <= r_rdptr + PW'(1);
      if (w_consume)
        r_pc <= r_pc + w_pc_step;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wrptr] <= i_ribm_rdata;
  end

  assign o_inst_pc      = r_pc;
  assign o_inst_is16    = w_is16;
  assign o_inst_vld     = w_vld;
  assign o_misalign_err = r_err;
  assign o_ribm_addr    = 32'(r_fa);
  assign o_ribm_wrcs    = 1'b0;
  assign o_ribm_mask    = 4'b1111;
  assign o_ribm_wdata   = 32'h0000_0000;
  assign o_ribm_req     = w_req;
  assign o_ribm_rdy     = i_ribm_rsp;

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
module tb_ifu_prefetch_buf;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;

  logic        clk;
  logic        i_rstn;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_is16;
  logic        o_inst_vld;
  logic        i_inst_rdy;
  logic        o_misalign_err;
  logic [31:0] o_ribm_addr;
  logic        o_ribm_wrcs;
  logic [3:0]  o_ribm_mask;
  logic [31:0] o_ribm_wdata;
  logic [31:0] i_ribm_rdata;
  logic        o_ribm_req;
  logic        i_ribm_gnt;
  logic        i_ribm_rsp;
  logic        o_ribm_rdy;

  ifu_prefetch_buf #(
    .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
  ) u_dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_is16(o_inst_is16),
    .o_inst_vld(o_inst_vld), .i_inst_rdy(i_inst_rdy),
    .o_misalign_err(o_misalign_err), .o_ribm_addr(o_ribm_addr),
    .o_ribm_wrcs(o_ribm_wrcs), .o_ribm_mask(o_ribm_mask),
    .o_ribm_wdata(o_ribm_wdata), .i_ribm_rdata(i_ribm_rdata),
    .o_ribm_req(o_ribm_req), .i_ribm_gnt(i_ribm_gnt), .i_ribm_rsp(i_ribm_rsp),
    .o_ribm_rdy(o_ribm_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is16;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  logic [31:0] mem_tbl [bit [31:0]];

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          n_gnt = 0;
  int          fresh_rsp = 0;
  int          min_words = 0;
  bit          seen_vld = 0;
  bit          do_flush = 0;
  bit          rstn_v = 0;
  logic [31:0] flush_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (mem_tbl.exists(a))
      return mem_tbl[a];
    return {a[15:0], 16'h0013};
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, the DUT
  // updates on the following rising edge.
  task automatic cycle();
    bit   fresh;
    exp_t e;
    @(negedge clk);
    i_rstn = rstn_v;
    if (!rstn_v)
      pend.delete();
    i_flush    = do_flush;
    i_flush_pc = flush_addr;
    if (do_flush) begin
      epoch++;
      n_gnt     = 0;
      fresh_rsp = 0;
      seen_vld  = 0;
    end
    i_ribm_rsp   = 1'b0;
    i_ribm_rdata = '0;
    fresh        = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      i_ribm_rsp   = 1'b1;
      i_ribm_rdata = memf(pend[0].addr);
      fresh        = (pend[0].ep == epoch);
      void'(pend.pop_front());
    end
    i_inst_rdy = (sb.size() > 0);
    i_ribm_gnt = 1'b1;
    #1;
    chk("rdy_eq_rsp", o_ribm_rdy, i_ribm_rsp);
    if (do_flush || !rstn_v)
      chk("vld_blocked", o_inst_vld, 0);
    if (o_inst_vld && !seen_vld) begin
      seen_vld = 1;
      if (min_words > 0)
        chk("span_wait", fresh_rsp >= min_words, 1);
    end
    if (o_ribm_req && i_ribm_gnt) begin
      pend.push_back('{o_ribm_addr, cyc + lat, epoch});
      n_gnt++;
    end
    if (i_ribm_rsp && fresh)
      fresh_rsp++;
    if (o_inst_vld && i_inst_rdy) begin
      e = sb.pop_front();
      chk("inst_pc", o_inst_pc, e.pc);
      chk("inst", o_inst, e.inst);
      chk("is16", o_inst_is16, e.is16);
    end
    cyc++;
    do_flush = 0;
  endtask

  task automatic flush_to(input logic [31:0] a);
    do_flush   = 1;
    flush_addr = a;
    cycle();
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst, input logic is16);
    sb.push_back('{pc, inst, is16});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 0; i_flush = 0; i_flush_pc = '0; i_inst_rdy = 0;
    i_ribm_rdata = '0; i_ribm_gnt = 0; i_ribm_rsp = 0;
    mem_tbl[32'h0]   = 32'h0000_0013;
    mem_tbl[32'h4]   = 32'h0010_0093;
    mem_tbl[32'h40]  = 32'h4505_0001;
    mem_tbl[32'h44]  = 32'h0000_0013;
    mem_tbl[32'h100] = 32'h0093_1234;
    mem_tbl[32'h104] = 32'h5678_0010;
    mem_tbl[32'h200] = 32'h00A0_0093;
    mem_tbl[32'h300] = 32'hDEAD_BEEF;
    mem_tbl[32'h304] = 32'hCAFE_F00D;

    // reset and the first two fetches
    rstn_v = 0;
    cycle();
    cycle();
    chk("rst_vld", o_inst_vld, 0);
    chk("rst_req", o_ribm_req, 0);
    chk("rst_err", o_misalign_err, 0);
    cycle();
    chk("wrcs", o_ribm_wrcs, 0);
    chk("mask", o_ribm_mask, 4'hF);
    chk("wdata", o_ribm_wdata, 0);
    expect_inst(32'h0, 32'h0000_0013, 0);
    expect_inst(32'h4, 32'h0010_0093, 0);
    rstn_v = 1;
    lat = 1;
    cycle();
    chk("req_first", o_ribm_req, 1);
    chk("addr_first", o_ribm_addr, 32'h0);
    cycle();
    chk("addr_second", o_ribm_addr, 32'h4);
    drain(50);

    // two compressed instructions in one word
    flush_to(32'h40);
    expect_inst(32'h40, 32'h0000_0001, 1);
    expect_inst(32'h42, 32'h0000_4505, 1);
    expect_inst(32'h44, 32'h0000_0013, 0);
    drain(50);

    // 32-bit instruction spanning two words
    min_words = 2;
    flush_to(32'h102);
    expect_inst(32'h102, 32'h0010_0093, 0);
    expect_inst(32'h106, 32'h0000_5678, 1);
    drain(50);
    min_words = 0;

    // flush with two reads in flight: both stale responses dropped
    idle(10);
    lat = 3;
    flush_to(32'h300);
    cycle();
    cycle();
    chk("two_outstanding", n_gnt, 2);
    flush_to(32'h200);
    expect_inst(32'h200, 32'h00A0_0093, 0);
    expect_inst(32'h204, 32'h0204_0013, 0);
    drain(60);
    lat = 1;

    // backpressure: credit stops issue at FIFO_DEPTH words
    idle(10);
    flush_to(32'h400);
    idle(14);
    chk("bp_grants", n_gnt, DEPTH);
    chk("bp_req", o_ribm_req, 0);
    for (int i = 0; i < 6; i++)
      expect_inst(32'h400 + 32'(4 * i), {16'(32'h400 + 4 * i), 16'h0013}, 0);
    drain(60);
    chk("bp_resume", n_gnt > DEPTH, 1);

    // misaligned redirect halts fetch until an even redirect
    idle(10);
    flush_to(32'h201);
    cycle();
    chk("err_set", o_misalign_err, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("err_req", o_ribm_req, 0);
      chk("err_vld", o_inst_vld, 0);
    end
    flush_to(32'h200);
    cycle();
    chk("err_clr", o_misalign_err, 0);
    expect_inst(32'h200, 32'h00A0_0093, 0);
    expect_inst(32'h204, 32'h0204_0013, 0);
    drain(50);

    // address wrap-around
    flush_to(32'hFFFF_FFFC);
    expect_inst(32'hFFFF_FFFC, 32'hFFFC_0013, 0);
    expect_inst(32'h0, 32'h0000_0013, 0);
    expect_inst(32'h4, 32'h0010_0093, 0);
    drain(50);

    // reset while reads are in flight and the error flag is set
    idle(10);
    lat = 3;
    flush_to(32'h500);
    cycle();
    cycle();
    flush_to(32'h501);
    cycle();
    chk("err_pre_rst", o_misalign_err, 1);
    rstn_v = 0;
    cycle();
    cycle();
    chk("rst2_err", o_misalign_err, 0);
    chk("rst2_req", o_ribm_req, 0);
    rstn_v = 1;
    lat = 1;
    expect_inst(32'h0, 32'h0000_0013, 0);
    expect_inst(32'h4, 32'h0010_0093, 0);
    drain(50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
